chg_fetch_seq: RTL and testbench

Upstream sequencer for the Y-matrix update datapath. It walks the change-record SRAM: one header word holds the record count, followed by packed records of row, col, real and img. It presents one record at a time on the chgTxt inputs of the Y-update top level. It advances only when the downstream write path signals that the record has been written back, and flags when the whole change list has been applied.

---
 rtl/chg_fetch_seq_pkg.sv | 35 +++
 rtl/chg_rec_unpack.sv | 18 +
 rtl/chg_fetch_seq.sv | 193 +++++++++++++++++++
 tb/tb_chg_fetch_seq.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chg_fetch_seq_pkg.sv
// Shared definitions for the change-record fetch sequencer: FSM state
// encoding, record field layout and header count width.
package chg_fetch_seq_pkg;

  // Packed change record: row, col, real, img from MSB to LSB.
  localparam int REC_W  = 80;
  localparam int ROW_HI = 79;
  localparam int ROW_LO = 64;
  localparam int COL_HI = 63;
  localparam int COL_LO = 48;
  localparam int RE_HI  = 47;
  localparam int RE_LO  = 24;
  localparam int IM_HI  = 23;
  localparam int IM_LO  = 0;

  // The header word carries the record count in its low bits. The field is
  // wider than the address so that an oversized count can be seen and clamped.
  localparam int HDR_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR_RD  = 3'd1,
    ST_HDR_CAP = 3'd2,
    ST_REC_RD  = 3'd3,
    ST_REC_CAP = 3'd4,
    ST_PRESENT = 3'd5,
    ST_DONE    = 3'd6
  } chg_state_e;

  // A pass is in flight in every state except the two resting states.
  function automatic logic state_is_busy(input chg_state_e s);
    return !((s == ST_IDLE) || (s == ST_DONE));
  endfunction

endpackage

// File: rtl/chg_rec_unpack.sv
// Combinational slice of one packed change record into its four fields.
// No arithmetic: the fields are passed through bit for bit.
module chg_rec_unpack
  import chg_fetch_seq_pkg::*;
(
  input  logic [REC_W-1:0] word,
  output logic [15:0]      row,
  output logic [15:0]      col,
  output logic [23:0]      re,
  output logic [23:0]      im
);

  assign row = word[ROW_HI:ROW_LO];
  assign col = word[COL_HI:COL_LO];
  assign re  = word[RE_HI:RE_LO];
  assign im  = word[IM_HI:IM_LO];

endmodule

// File: rtl/chg_fetch_seq.sv
// Change-record fetch sequencer. Reads the header count from SRAM word 0,
// then presents records 1..count one at a time, advancing on each rec_done
// from the Y write path, and raises all_done once the list is applied.
//
// Handshake: rec_valid high means the rec_* fields are stable and owned by
// the downstream stage. They stay frozen until a rising rec_done is seen in
// PRESENT; that edge drops rec_valid and releases the next record. rec_done
// outside PRESENT is ignored, and a rec_done held high counts only once.
module chg_fetch_seq
  import chg_fetch_seq_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [REC_W-1:0]  chg_rdata,
  input  logic              rec_done,
  output logic [ADDR_W-1:0] chg_addr,
  output logic [15:0]       rec_row,
  output logic [15:0]       rec_col,
  output logic [23:0]       rec_real,
  output logic [23:0]       rec_img,
  output logic              rec_valid,
  output logic [ADDR_W-1:0] rec_index,
  output logic              busy,
  output logic              all_done,
  output chg_state_e        dbg_state
);

  // Largest record address; the count is clamped here so the address
  // increment can never wrap.
  localparam logic [ADDR_W-1:0] CNT_MAX = '1;

  chg_state_e        state;
  chg_state_e        state_next;
  logic [ADDR_W-1:0] count;
  logic              rec_done_q;

  // Control strobes decoded by the FSM for the datapath registers.
  logic              addr_clr;
  logic              hdr_load;
  logic              rec_load;
  logic              rec_adv;
  logic              rec_release;

  logic              done_rise;
  logic              last_rec;
  logic [HDR_CNT_W-1:0] hdr_cnt;
  logic              hdr_zero;
  logic [ADDR_W-1:0] hdr_clamped;

  logic [15:0]       unp_row;
  logic [15:0]       unp_col;
  logic [23:0]       unp_re;
  logic [23:0]       unp_im;

  chg_rec_unpack u_unpack (
    .word (chg_rdata),
    .row  (unp_row),
    .col  (unp_col),
    .re   (unp_re),
    .im   (unp_im)
  );

  assign done_rise   = rec_done & ~rec_done_q;
  assign last_rec    = (rec_index == count);
  assign hdr_cnt     = chg_rdata[HDR_CNT_W-1:0];
  assign hdr_zero    = (hdr_cnt == '0);
  assign hdr_clamped = (hdr_cnt > HDR_CNT_W'(CNT_MAX)) ? CNT_MAX
                                                       : hdr_cnt[ADDR_W-1:0];

  assign busy      = state_is_busy(state);
  assign all_done  = (state == ST_DONE);
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and datapath strobes; abort overrides everything.
  always_comb begin
    state_next  = state;
    addr_clr    = 1'b0;
    hdr_load    = 1'b0;
    rec_load    = 1'b0;
    rec_adv     = 1'b0;
    rec_release = 1'b0;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            addr_clr   = 1'b1;
            state_next = ST_HDR_RD;
          end
        end
        ST_HDR_RD: begin
          state_next = ST_HDR_CAP;
        end
        ST_HDR_CAP: begin
          hdr_load   = 1'b1;
          state_next = hdr_zero ? ST_DONE : ST_REC_RD;
        end
        ST_REC_RD: begin
          state_next = ST_REC_CAP;
        end
        ST_REC_CAP: begin
          rec_load   = 1'b1;
          state_next = ST_PRESENT;
        end
        ST_PRESENT: begin
          if (done_rise) begin
            rec_release = 1'b1;
            if (last_rec) begin
              state_next = ST_DONE;
            end else begin
              rec_adv    = 1'b1;
              state_next = ST_REC_RD;
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Address, index and count registers; these keep their values on abort.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      chg_addr  <= '0;
      rec_index <= '0;
      count     <= '0;
    end else begin
      if (addr_clr) begin
        chg_addr <= '0;
      end
      if (hdr_load) begin
        count <= hdr_clamped;
        if (!hdr_zero) begin
          chg_addr  <= ADDR_W'(1);
          rec_index <= ADDR_W'(1);
        end
      end
      if (rec_adv) begin
        chg_addr  <= chg_addr + ADDR_W'(1);
        rec_index <= rec_index + ADDR_W'(1);
      end
    end
  end

  // Record field capture; fields hold until the next record is captured.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rec_row  <= '0;
      rec_col  <= '0;
      rec_real <= '0;
      rec_img  <= '0;
    end else if (rec_load) begin
      rec_row  <= unp_row;
      rec_col  <= unp_col;
      rec_real <= unp_re;
      rec_img  <= unp_im;
    end
  end

  // rec_valid ownership flag plus the rec_done history for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rec_valid  <= 1'b0;
      rec_done_q <= 1'b0;
    end else begin
      rec_done_q <= rec_done;
      if (abort) begin
        rec_valid <= 1'b0;
      end else if (rec_load) begin
        rec_valid <= 1'b1;
      end else if (rec_release) begin
        rec_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_chg_fetch_seq.sv
// Directed bench for chg_fetch_seq: a table of hand-computed records for the
// main pass, plus hand-written sequences for header 0, spurious rec_done,
// abort, asynchronous reset and count clamping on a 4-bit address instance.
module tb_chg_fetch_seq;
  import chg_fetch_seq_pkg::*;

  // Clock and reset.
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // Main instance, ADDR_W = 11.
  logic        start, abort, rec_done;
  logic [79:0] chg_rdata;
  logic [10:0] chg_addr, rec_index;
  logic [15:0] rec_row, rec_col;
  logic [23:0] rec_real, rec_img;
  logic        rec_valid, busy, all_done;
  chg_state_e  dbg_state;

  // Small instance, ADDR_W = 4, for count clamping.
  logic        start4, abort4, rec_done4;
  logic [79:0] chg_rdata4;
  logic [3:0]  chg_addr4, rec_index4;
  logic [15:0] rec_row4, rec_col4;
  logic [23:0] rec_real4, rec_img4;
  logic        rec_valid4, busy4, all_done4;
  chg_state_e  dbg_state4;

  chg_fetch_seq #(.ADDR_W(11)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .chg_rdata(chg_rdata), .rec_done(rec_done), .chg_addr(chg_addr),
    .rec_row(rec_row), .rec_col(rec_col), .rec_real(rec_real),
    .rec_img(rec_img), .rec_valid(rec_valid), .rec_index(rec_index),
    .busy(busy), .all_done(all_done), .dbg_state(dbg_state)
  );

  chg_fetch_seq #(.ADDR_W(4)) dut4 (
    .clock(clock), .reset(reset), .start(start4), .abort(abort4),
    .chg_rdata(chg_rdata4), .rec_done(rec_done4), .chg_addr(chg_addr4),
    .rec_row(rec_row4), .rec_col(rec_col4), .rec_real(rec_real4),
    .rec_img(rec_img4), .rec_valid(rec_valid4), .rec_index(rec_index4),
    .busy(busy4), .all_done(all_done4), .dbg_state(dbg_state4)
  );

  // Change SRAM models: one cycle read latency.
  logic [79:0] mem  [0:2047];
  logic [79:0] mem4 [0:15];
  always @(posedge clock) chg_rdata  <= mem[chg_addr];
  always @(posedge clock) chg_rdata4 <= mem4[chg_addr4];

  // Scoreboard counters and record table.
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [79:0] word;
    logic [15:0] row;
    logic [15:0] col;
    logic [23:0] re;
    logic [23:0] im;
  } rec_vec_t;
  rec_vec_t tbl [3];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Driver tasks: advance to just past the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_done();
    rec_done = 1'b1;
    tick();
    rec_done = 1'b0;
  endtask

  // Bounded wait for rec_valid; n is the number of edges consumed.
  task automatic wait_valid(output int n);
    n = 0;
    while (!rec_valid && n < 20) begin
      tick();
      n++;
    end
    chk("valid_timeout", 80'(rec_valid), 80'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int busy_cnt;
    int valid_seen;

    reset = 1'b0; start = 1'b0; abort = 1'b0; rec_done = 1'b0;
    start4 = 1'b0; abort4 = 1'b0; rec_done4 = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    for (int i = 0; i < 16; i++) mem4[i] = '0;

    tbl[0] = '{80'h0001_0002_000100_FFFF00, 16'h0001, 16'h0002, 24'h000100, 24'hFFFF00};
    tbl[1] = '{80'h0005_0005_7FFFFF_000000, 16'h0005, 16'h0005, 24'h7FFFFF, 24'h000000};
    tbl[2] = '{80'h0002_0001_000000_000001, 16'h0002, 16'h0001, 24'h000000, 24'h000001};
    for (int k = 0; k < 3; k++) mem[k+1] = tbl[k].word;

    // Reset state.
    repeat (2) tick();
    chk("rst_addr",     80'(chg_addr),  80'(0));
    chk("rst_row",      80'(rec_row),   80'(0));
    chk("rst_valid",    80'(rec_valid), 80'(0));
    chk("rst_index",    80'(rec_index), 80'(0));
    chk("rst_busy",     80'(busy),      80'(0));
    chk("rst_all_done", 80'(all_done),  80'(0));
    chk("rst_state",    80'(dbg_state), 80'(ST_IDLE));
    reset = 1'b1;
    repeat (2) tick();
    chk("idle_after_rst", 80'(dbg_state), 80'(ST_IDLE));

    // Main pass: header 3, rec_done two cycles after each rec_valid.
    mem[0] = 80'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_addr0",  80'(chg_addr),  80'(0));
    chk("t1_busy",   80'(busy),      80'(1));
    chk("t1_hdr_rd", 80'(dbg_state), 80'(ST_HDR_RD));
    repeat (2) tick();
    chk("t1_addr1",  80'(chg_addr),  80'(1));
    chk("t1_index1", 80'(rec_index), 80'(1));
    chk("t1_novalid", 80'(rec_valid), 80'(0));
    wait_valid(n);
    chk("t1_first_lat", 80'(n), 80'(2));
    for (int k = 0; k < 3; k++) begin
      chk("t1_row",   80'(rec_row),   80'(tbl[k].row));
      chk("t1_col",   80'(rec_col),   80'(tbl[k].col));
      chk("t1_real",  80'(rec_real),  80'(tbl[k].re));
      chk("t1_img",   80'(rec_img),   80'(tbl[k].im));
      chk("t1_index", 80'(rec_index), 80'(k + 1));
      repeat (2) tick();
      chk("t1_hold_valid", 80'(rec_valid), 80'(1));
      chk("t1_hold_col",   80'(rec_col),   80'(tbl[k].col));
      pulse_done();
      chk("t1_release", 80'(rec_valid), 80'(0));
      if (k < 2) begin
        wait_valid(n);
        chk("t1_gap", 80'(n + 1), 80'(3));
      end else begin
        chk("t1_all_done", 80'(all_done), 80'(1));
        chk("t1_idle_busy", 80'(busy), 80'(0));
      end
    end

    // Header 0, restarted from DONE.
    mem[0] = 80'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_clear_done", 80'(all_done), 80'(0));
    n = 1;
    busy_cnt = busy ? 1 : 0;
    valid_seen = 0;
    while (!all_done && n < 20) begin
      tick();
      n++;
      if (busy) busy_cnt++;
      if (rec_valid) valid_seen = 1;
    end
    chk("t2_done_lat", 80'(n),          80'(3));
    chk("t2_busy_cnt", 80'(busy_cnt),   80'(2));
    chk("t2_no_valid", 80'(valid_seen), 80'(0));
    repeat (3) tick();
    chk("t2_done_held", 80'(all_done), 80'(1));

    // Spurious rec_done in IDLE and REC_CAP, then a held rec_done.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t3_abort_done", 80'(all_done), 80'(0));
    pulse_done();
    chk("t3_idle_state", 80'(dbg_state), 80'(ST_IDLE));
    chk("t3_idle_valid", 80'(rec_valid), 80'(0));
    mem[0] = 80'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("t3_rec_cap", 80'(dbg_state), 80'(ST_REC_CAP));
    pulse_done();
    repeat (2) tick();
    chk("t3_capdone_valid", 80'(rec_valid), 80'(1));
    chk("t3_capdone_index", 80'(rec_index), 80'(1));
    rec_done = 1'b1;
    repeat (4) tick();
    rec_done = 1'b0;
    chk("t3_held_valid", 80'(rec_valid), 80'(1));
    chk("t3_held_index", 80'(rec_index), 80'(2));
    chk("t3_held_row",   80'(rec_row),   80'(16'h0005));
    repeat (2) tick();
    chk("t3_held_stable", 80'(rec_index), 80'(2));
    pulse_done();
    wait_valid(n);
    chk("t3_index3", 80'(rec_index), 80'(3));
    pulse_done();
    chk("t3_all_done", 80'(all_done), 80'(1));

    // Abort during the second PRESENT, then restart.
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(n);
    chk("t4_first_lat", 80'(n), 80'(4));
    pulse_done();
    wait_valid(n);
    chk("t4_index2", 80'(rec_index), 80'(2));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_state",    80'(dbg_state), 80'(ST_IDLE));
    chk("t4_valid",    80'(rec_valid), 80'(0));
    chk("t4_all_done", 80'(all_done),  80'(0));
    chk("t4_busy",     80'(busy),      80'(0));
    chk("t4_addr_kept", 80'(chg_addr), 80'(2));
    chk("t4_row_kept", 80'(rec_row),   80'(16'h0005));
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(n);
    chk("t4_restart_lat", 80'(n),         80'(4));
    chk("t4_restart_idx", 80'(rec_index), 80'(1));
    chk("t4_restart_row", 80'(rec_row),   80'(16'h0001));
    chk("t4_restart_img", 80'(rec_img),   80'(24'hFFFF00));

    // Asynchronous reset while in REC_RD.
    pulse_done();
    chk("t5_rec_rd", 80'(dbg_state), 80'(ST_REC_RD));
    #2;
    reset = 1'b0;
    #1;
    chk("t5_addr",  80'(chg_addr),  80'(0));
    chk("t5_row",   80'(rec_row),   80'(0));
    chk("t5_img",   80'(rec_img),   80'(0));
    chk("t5_valid", 80'(rec_valid), 80'(0));
    chk("t5_index", 80'(rec_index), 80'(0));
    chk("t5_busy",  80'(busy),      80'(0));
    chk("t5_state", 80'(dbg_state), 80'(ST_IDLE));
    repeat (2) tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_post_valid", 80'(rec_valid), 80'(0));
      chk("t5_post_busy",  80'(busy),      80'(0));
    end

    // Count clamping on the 4-bit instance: header 0xFFFF -> 15 records.
    mem4[0] = 80'h0000_0000_000000_00FFFF;
    for (int i = 1; i < 16; i++)
      mem4[i] = {16'(i), 16'(i + 100), 24'(i * 3), 24'(i) ^ 24'hA5A5A5};
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int i = 1; i < 16; i++) begin
      n = 0;
      while (!rec_valid4 && n < 20) begin
        tick();
        n++;
      end
      chk("t6_valid",  80'(rec_valid4), 80'(1));
      chk("t6_index",  80'(rec_index4), 80'(i));
      chk("t6_addr",   80'(chg_addr4),  80'(i));
      chk("t6_row",    80'(rec_row4),   80'(i));
      chk("t6_img",    80'(rec_img4),   80'(24'(i) ^ 24'hA5A5A5));
      rec_done4 = 1'b1;
      tick();
      rec_done4 = 1'b0;
    end
    chk("t6_all_done", 80'(all_done4),  80'(1));
    chk("t6_last_addr", 80'(chg_addr4), 80'(15));
    chk("t6_no_valid", 80'(rec_valid4), 80'(0));
    repeat (2) tick();
    chk("t6_no_wrap",  80'(chg_addr4),  80'(15));
    chk("t6_state",    80'(dbg_state4), 80'(ST_DONE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
